alu_uart_sequencer: RTL

Control stage directly upstream of the ALU. It assembles one ALU operation from three bytes delivered by the UART receiver, in the order operand A, operand B, opcode, and drives the ALU's BusA, BusB and OpCode inputs from registers. It then captures the ALU Result and hands it to the UART transmitter as one byte, waiting for transmit completion before it accepts the next operation.

---
 rtl/alu_uart_sequencer_if.sv | 45 ++++
 rtl/alu_uart_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer_if.sv
// Byte-stream and ALU-facing signal bundle for the ALU/UART sequencer.
// The sequencer side uses the master modport; the UART/ALU side uses slave.
interface alu_uart_sequencer_if #(
  parameter int N = 8
);
  logic [7:0]   rx_data;
  logic         rx_done;
  logic [N-1:0] alu_result;
  logic [N-1:0] bus_a;
  logic [N-1:0] bus_b;
  logic [5:0]   opcode;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_done;
  logic         busy;
  logic         overrun;

  modport master (
    input  rx_data,
    input  rx_done,
    input  alu_result,
    input  tx_done,
    output bus_a,
    output bus_b,
    output opcode,
    output tx_data,
    output tx_start,
    output busy,
    output overrun
  );

  modport slave (
    output rx_data,
    output rx_done,
    output alu_result,
    output tx_done,
    input  bus_a,
    input  bus_b,
    input  opcode,
    input  tx_data,
    input  tx_start,
    input  busy,
    input  overrun
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, drives the
// ALU from registers, then sends the ALU result back as one byte and waits for tx_done.
module alu_uart_sequencer #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_uart_sequencer_if.master  sif
);

  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] CALC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  logic [2:0]   state_reg,   state_next;
  logic [N-1:0] bus_a_reg,   bus_a_next;
  logic [N-1:0] bus_b_reg,   bus_b_next;
  logic [5:0]   opcode_reg,  opcode_next;
  logic [7:0]   tx_data_reg, tx_data_next;
  logic         overrun_reg, overrun_next;
  logic [7:0]   result_ext;

  // Zero-extend the N-bit ALU result into the transmit byte.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_result_ext
      if (gi < N) begin : g_data
        assign result_ext[gi] = sif.alu_result[gi];
      end else begin : g_zero
        assign result_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    bus_a_next   = bus_a_reg;
    bus_b_next   = bus_b_reg;
    opcode_next  = opcode_reg;
    tx_data_next = tx_data_reg;
    overrun_next = overrun_reg;
    case (state_reg)
      WAIT_A: begin
        if (sif.rx_done) begin
          bus_a_next   = sif.rx_data[N-1:0];
          overrun_next = 1'b0;
          state_next   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (sif.rx_done) begin
          bus_b_next = sif.rx_data[N-1:0];
          state_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (sif.rx_done) begin
          opcode_next = sif.rx_data[5:0];
          state_next  = CALC;
        end
      end
      CALC: begin
        tx_data_next = result_ext;
        state_next   = SEND;
        if (sif.rx_done) begin
          overrun_next = 1'b1;
        end
      end
      SEND: begin
        state_next = WAIT_TX;
        if (sif.rx_done) begin
          overrun_next = 1'b1;
        end
      end
      WAIT_TX: begin
        // A byte arriving here is discarded even if tx_done ends the transaction.
        if (sif.rx_done) begin
          overrun_next = 1'b1;
        end
        if (sif.tx_done) begin
          state_next = WAIT_A;
        end
      end
      default: begin
        state_next = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= WAIT_A;
      bus_a_reg   <= '0;
      bus_b_reg   <= '0;
      opcode_reg  <= '0;
      tx_data_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bus_a_reg   <= bus_a_next;
      bus_b_reg   <= bus_b_next;
      opcode_reg  <= opcode_next;
      tx_data_reg <= tx_data_next;
      overrun_reg <= overrun_next;
    end
  end

  assign sif.bus_a    = bus_a_reg;
  assign sif.bus_b    = bus_b_reg;
  assign sif.opcode   = opcode_reg;
  assign sif.tx_data  = tx_data_reg;
  assign sif.overrun  = overrun_reg;
  assign sif.tx_start = (state_reg == SEND);
  assign sif.busy     = (state_reg != WAIT_A);

endmodule
